// File: rtl/icache_refill_ctrl_pkg.sv
// icache_refill_ctrl_pkg: refill state encoding and line geometry shared by cache, fetch and refill logic
package icache_refill_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_FILL,
        ST_HOLD
    } refill_state_e;

    localparam int LINE_BYTES  = 16;
    localparam int WORD_BYTES  = 4;
    localparam int OFFSET_BITS = 4;

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// icache_refill_ctrl_if: fetch miss, instruction-memory and cache-line signals of the refill controller
interface icache_refill_ctrl_if #(
    parameter int ADDR_W     = 64,
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 4
);
    logic                         miss;
    logic [ADDR_W-1:0]            miss_addr;
    logic                         busy;
    logic                         mem_req;
    logic [ADDR_W-1:0]            mem_addr;
    logic                         mem_ready;
    logic [WORD_W-1:0]            mem_rdata;
    logic [LINE_WORDS*WORD_W-1:0] data_line;
    logic [ADDR_W-1:0]            line_addr;
    logic                         line_valid;

    modport master (
        input  miss, miss_addr, mem_ready, mem_rdata,
        output busy, mem_req, mem_addr, data_line, line_addr, line_valid
    );

    modport slave (
        output miss, miss_addr, mem_ready, mem_rdata,
        input  busy, mem_req, mem_addr, data_line, line_addr, line_valid
    );
endinterface

// File: rtl/icache_refill_ctrl_line_buf.sv
// refill_line_buf: shadow line collecting memory beats one word at a time before the line is published
module refill_line_buf #(
    parameter int WORDS  = 4,
    parameter int WORD_W = 32,
    parameter int IDX_W  = $clog2(WORDS)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    we,
    input  logic [IDX_W-1:0]        idx,
    input  logic [WORD_W-1:0]       wdata,
    output logic [WORDS*WORD_W-1:0] line
);
    logic [WORDS*WORD_W-1:0] line_q, line_d;

    // Overwrite only the addressed word; the rest of the line keeps its value
    always_comb begin
        line_d = line_q;
        if (we)
            line_d[int'(idx)*WORD_W +: WORD_W] = wdata;
    end

    // Shadow storage, cleared on reset so an aborted refill leaves nothing behind
    always_ff @(posedge clock) begin
        if (reset)
            line_q <= '0;
        else
            line_q <= line_d;
    end

    assign line = line_q;
endmodule

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: on an I-cache miss fetches the 4-word line in order and presents it to the cache
module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input logic                 clock,
    input logic                 reset,
    icache_refill_ctrl_if.master bus
);
    localparam int CNT_W  = $clog2(LINE_WORDS);
    localparam int LINE_W = LINE_WORDS * WORD_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LINE_WORDS - 1);

    refill_state_e     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] line_addr_q, line_addr_d;
    logic [LINE_W-1:0] data_line_q, data_line_d;
    logic              line_valid_q, line_valid_d;
    logic              busy_q, busy_d;
    logic              beat;
    logic [LINE_W-1:0] shadow;

    assign beat = (state_q == ST_FETCH) && mem_req_q && bus.mem_ready;

    refill_line_buf #(
        .WORDS (LINE_WORDS),
        .WORD_W(WORD_W)
    ) u_line_buf (
        .clock(clock),
        .reset(reset),
        .we   (beat),
        .idx  (cnt_q),
        .wdata(bus.mem_rdata),
        .line (shadow)
    );

    // Next-state and next-output logic; every output is registered, so each state's action shows a cycle later
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        line_addr_d  = line_addr_q;
        data_line_d  = data_line_q;
        line_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.miss) begin
                    line_addr_d = {bus.miss_addr[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                    mem_addr_d  = {bus.miss_addr[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    state_d     = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        mem_req_d = 1'b0;
                        state_d   = ST_FILL;
                    end else begin
                        mem_addr_d = mem_addr_q + ADDR_W'(WORD_BYTES);
                    end
                end
            end
            ST_FILL: begin
                data_line_d  = shadow;
                line_valid_d = 1'b1;
                state_d      = ST_HOLD;
            end
            ST_HOLD: state_d = ST_IDLE;
        endcase
        // Stall covers the accepting cycle and the cycle after HOLD, when the cache re-looks-up
        busy_d = (state_d != ST_IDLE) || (state_q != ST_IDLE);
    end

    // State and output registers; reset abandons any refill in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            line_addr_q  <= '0;
            data_line_q  <= '0;
            line_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            line_addr_q  <= line_addr_d;
            data_line_q  <= data_line_d;
            line_valid_q <= line_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.line_addr  = line_addr_q;
    assign bus.data_line  = data_line_q;
    assign bus.line_valid = line_valid_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: scoreboard bench for the I-cache refill controller with a word-addressed memory model
module tb_icache_refill_ctrl;

    typedef struct {
        logic [63:0] a;
        bit          last;
    } beat_t;

    typedef struct {
        logic [63:0]  a;
        logic [127:0] d;
    } line_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    icache_refill_ctrl_if bus ();

    icache_refill_ctrl dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    beat_t exp_beats[$];
    line_t exp_lines[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    beats = 0;
    int    lv_cnt = 0;
    int    lv_cyc = 0;
    int    last_beat_cyc = 0;
    int    mode = 0;
    int    granted = 0;
    int    stalled = 0;
    logic  prev_rst = 1'b1;
    logic [127:0] prev_dl = '0;
    beat_t mb;
    line_t ml;

    // Instruction memory contents: the spec test words near 0x1230, a scrambled address elsewhere
    function automatic logic [31:0] mem_f(input logic [63:0] a);
        if (a >= 64'h1230 && a <= 64'h123C)
            return 32'hA0 + 32'((a - 64'h1230) >> 2);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32];
    endfunction

    assign bus.mem_rdata = mem_f(bus.mem_addr);

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clock) cyc++;

    // Memory acceptance: always ready, random, or two wait cycles in front of the third beat
    always begin
        logic r;
        @(posedge clock);
        #1;
        if (bus.mem_req !== 1'b1) begin
            granted = 0;
            stalled = 0;
        end
        if (mode == 0)
            r = 1'b1;
        else if (mode == 1)
            r = ($urandom_range(0, 3) != 0);
        else if (bus.mem_req === 1'b1 && granted == 2 && stalled < 2) begin
            r = 1'b0;
            stalled++;
        end else
            r = 1'b1;
        bus.mem_ready = r;
        if (bus.mem_req === 1'b1 && r)
            granted++;
    end

    // Monitor: pops expected beats and lines whenever the DUT presents them
    always @(negedge clock) begin
        if (bus.mem_req === 1'b1) begin
            check("beat_expected", 128'(exp_beats.size() != 0), 128'd1);
            if (exp_beats.size() != 0) begin
                check("mem_addr", 128'(bus.mem_addr), 128'(exp_beats[0].a));
                if (bus.mem_ready === 1'b1) begin
                    mb = exp_beats.pop_front();
                    beats++;
                    if (mb.last)
                        last_beat_cyc = cyc;
                end
            end
        end
        if (bus.line_valid === 1'b1) begin
            check("line_expected", 128'(exp_lines.size() != 0), 128'd1);
            if (exp_lines.size() != 0) begin
                ml = exp_lines.pop_front();
                check("line_addr", 128'(bus.line_addr), 128'(ml.a));
                check("data_line", bus.data_line, ml.d);
                check("lv_after_last_beat", 128'(cyc - last_beat_cyc), 128'd2);
            end
            lv_cnt++;
            lv_cyc = cyc;
        end else if (!prev_rst)
            check("data_line_stable", bus.data_line, prev_dl);
        prev_dl  = bus.data_line;
        prev_rst = reset;
    end

    task automatic wait_idle();
        int t = 0;
        while (bus.busy !== 1'b0 && t < 200) begin
            @(negedge clock);
            t++;
        end
        check("idle_before_miss", 128'(bus.busy), 128'd0);
    endtask

    task automatic push_line(input logic [63:0] base);
        logic [127:0] ln;
        for (int k = 0; k < 4; k++) begin
            ln[32*k +: 32] = mem_f(base + 64'(4 * k));
            exp_beats.push_back('{a: base + 64'(4 * k), last: (k == 3)});
        end
        exp_lines.push_back('{a: base, d: ln});
    endtask

    // One refill: miss for one cycle, optionally keep a junk miss up, then follow to busy release
    task automatic do_refill(input logic [63:0] addr, input bit junk, input int rmode, input int exp_lat);
        logic [63:0] base;
        int c;
        int lv0;
        int t;
        base = {addr[63:4], 4'h0};
        wait_idle();
        @(posedge clock);
        #1;
        mode = rmode;
        push_line(base);
        bus.miss      = 1'b1;
        bus.miss_addr = addr;
        c   = cyc;
        lv0 = lv_cnt;
        @(posedge clock);
        #1;
        bus.miss      = junk;
        bus.miss_addr = {$urandom, $urandom};
        @(negedge clock);
        check("busy_after_miss", 128'(bus.busy), 128'd1);
        t = 0;
        while (t < 200) begin
            @(posedge clock);
            #1;
            if (lv_cnt != lv0)
                break;
            bus.miss      = junk && ($urandom_range(0, 1) == 1);
            bus.miss_addr = {$urandom, $urandom};
            t++;
        end
        bus.miss = 1'b0;
        check("line_valid_seen", 128'(lv_cnt - lv0), 128'd1);
        if (lv_cnt == lv0) begin
            exp_beats.delete();
            exp_lines.delete();
            return;
        end
        if (exp_lat >= 0)
            check("refill_latency", 128'(lv_cyc - c), 128'(exp_lat));
        check("fetch_word", 128'(bus.data_line[int'(addr[3:2])*32 +: 32]), 128'(mem_f({addr[63:2], 2'b00})));
        @(negedge clock);
        check("busy_hold", 128'(bus.busy), 128'd1);
        check("line_valid_pulse", 128'(bus.line_valid), 128'd0);
        @(negedge clock);
        check("busy_release", 128'(bus.busy), 128'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        int lv0;
        int t;
        bus.miss      = 1'b0;
        bus.miss_addr = '0;
        bus.mem_ready = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_mem_req", 128'(bus.mem_req), 128'd0);
        check("rst_mem_addr", 128'(bus.mem_addr), 128'd0);
        check("rst_data_line", bus.data_line, 128'd0);
        check("rst_line_addr", 128'(bus.line_addr), 128'd0);
        check("rst_line_valid", 128'(bus.line_valid), 128'd0);
        check("rst_busy", 128'(bus.busy), 128'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        do_refill(64'h0000_0000_0000_1234, 1'b0, 0, 6);
        check("spec_line", bus.data_line, 128'h000000A3_000000A2_000000A1_000000A0);
        do_refill(64'h0000_0000_0000_1234, 1'b0, 2, 8);
        do_refill(64'h0000_0000_0000_4008, 1'b1, 0, 6);
        do_refill(64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 0, 6);
        check("top_line_addr", 128'(bus.line_addr), 128'(64'hFFFF_FFFF_FFFF_FFF0));

        // Reset in the middle of a refill discards the partial line
        wait_idle();
        @(posedge clock);
        #1;
        mode = 0;
        push_line(64'h0000_0000_0002_0000);
        bus.miss      = 1'b1;
        bus.miss_addr = 64'h0000_0000_0002_0004;
        b0 = beats;
        @(posedge clock);
        #1;
        bus.miss = 1'b0;
        t = 0;
        while (beats < b0 + 2 && t < 50) begin
            @(negedge clock);
            t++;
        end
        check("beats_before_reset", 128'(beats - b0 >= 2), 128'd1);
        @(posedge clock);
        #1;
        reset         = 1'b1;
        bus.miss      = 1'b1;
        bus.miss_addr = 64'h0000_0000_0003_0000;
        @(posedge clock);
        #1;
        reset    = 1'b0;
        bus.miss = 1'b0;
        exp_beats.delete();
        exp_lines.delete();
        lv0 = lv_cnt;
        @(negedge clock);
        check("mid_rst_mem_req", 128'(bus.mem_req), 128'd0);
        check("mid_rst_busy", 128'(bus.busy), 128'd0);
        check("mid_rst_data_line", bus.data_line, 128'd0);
        check("mid_rst_line_valid", 128'(bus.line_valid), 128'd0);
        repeat (10) @(negedge clock);
        check("no_line_after_reset", 128'(lv_cnt - lv0), 128'd0);

        // Reset and miss together in IDLE: reset wins
        @(posedge clock);
        #1;
        reset         = 1'b1;
        bus.miss      = 1'b1;
        bus.miss_addr = 64'h0000_0000_0005_0000;
        @(posedge clock);
        #1;
        reset    = 1'b0;
        bus.miss = 1'b0;
        @(negedge clock);
        check("rst_miss_mem_req", 128'(bus.mem_req), 128'd0);
        check("rst_miss_busy", 128'(bus.busy), 128'd0);

        for (int i = 0; i < 25; i++) begin
            logic [63:0] a;
            a = ($urandom_range(0, 4) == 0) ? {60'hFFF_FFFF_FFFF_FFFF, 4'($urandom)} : {$urandom, $urandom};
            do_refill(a, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)), -1);
        end

        repeat (5) @(negedge clock);
        check("beats_drained", 128'(exp_beats.size()), 128'd0);
        check("lines_drained", 128'(exp_lines.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
